// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU op encoding and the decoded bundle.
// XLEN here sets the width of the imm field carried in decode_ctrl_t.
package decode_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  typedef enum logic [4:0] {
    AluAdd = 5'd0, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluOr, AluAnd, AluSrl, AluSra,
    AluMul = 5'd10, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu
  } alu_op_e;

  typedef enum logic [1:0] {SrcRs1 = 2'd0, SrcPc = 2'd1, SrcZero = 2'd2} src_a_e;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    src_a_e          src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            link;
    logic            illegal;
  } decode_ctrl_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  // Base integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction decoder producing decode_ctrl_t.
// Define DECODE_RV32M_EN to decode the M extension (funct7 = 0000001 on OP).
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]  instr,
  output decode_ctrl_t ctrl
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl           = '0;
    ctrl.rs1       = instr[19:15];
    ctrl.rs2       = instr[24:20];
    ctrl.rd        = instr[11:7];
    ctrl.funct3    = funct3;
    ctrl.alu_op    = AluAdd;
    ctrl.src_a     = SrcRs1;
    ctrl.alu_src_b = 1'b1;
    illegal        = (instr[1:0] != 2'b11);

    case (opcode)
      OpcLui: begin
        ctrl.imm       = sext(imm_u);
        ctrl.src_a     = SrcZero;
        ctrl.reg_write = 1'b1;
      end
      OpcAuipc: begin
        ctrl.imm       = sext(imm_u);
        ctrl.src_a     = SrcPc;
        ctrl.reg_write = 1'b1;
      end
      OpcJal: begin
        ctrl.imm       = sext(imm_j);
        ctrl.src_a     = SrcPc;
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OpcJalr: begin
        ctrl.imm       = sext(imm_i);
        ctrl.jump      = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        illegal        = illegal | (funct3 != 3'b000);
      end
      OpcBranch: begin
        ctrl.imm       = sext(imm_b);
        ctrl.alu_op    = AluSub;
        ctrl.alu_src_b = 1'b0;
        ctrl.branch    = 1'b1;
        illegal        = illegal | (funct3 == 3'b010) | (funct3 == 3'b011);
      end
      OpcLoad: begin
        ctrl.imm        = sext(imm_i);
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        illegal         = illegal | (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
      end
      OpcStore: begin
        ctrl.imm       = sext(imm_s);
        ctrl.mem_write = 1'b1;
        illegal        = illegal | (funct3 >= 3'b011);
      end
      OpcOpImm: begin
        ctrl.imm       = sext(imm_i);
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001) begin
          illegal = illegal | (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          illegal = illegal | ((funct7 != 7'b0000000) && (funct7 != 7'b0100000));
        end
      end
      OpcOp: begin
        ctrl.alu_src_b = 1'b0;
        ctrl.reg_write = 1'b1;
        case (funct7)
          7'b0000000: ctrl.alu_op = alu_base(funct3, 1'b0);
          7'b0100000: begin
            ctrl.alu_op = alu_base(funct3, 1'b1);
            illegal     = illegal | ((funct3 != 3'b000) && (funct3 != 3'b101));
          end
`ifdef DECODE_RV32M_EN
          7'b0000001: ctrl.alu_op = alu_op_e'(5'd10 + {2'b00, funct3});
`endif
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (ctrl.rd == 5'd0) ctrl.reg_write = 1'b0;
    // Illegal instrs must have no architectural side effects; execute raises the trap.
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
    end
    ctrl.illegal = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register plus one skid entry, valid/ready on both sides.
// Define DECODE_RV32M_EN to enable M-extension decode inside decode_comb.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned     XLEN     = decode_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output decode_ctrl_t      out_ctrl
);

  decode_ctrl_t    dec_ctrl;
  logic            or_valid_d, or_valid_q, sk_valid_d, sk_valid_q;
  decode_ctrl_t    or_ctrl_d, or_ctrl_q, sk_ctrl_d, sk_ctrl_q;
  logic [XLEN-1:0] or_pc_d, or_pc_q, sk_pc_d, sk_pc_q;
  logic            accept, or_free;

  decode_comb u_decode_comb (
    .instr (in_instr),
    .ctrl  (dec_ctrl)
  );

  // in_ready is a pure register output so fetch never sees a path from out_ready.
  assign in_ready  = ~sk_valid_q;
  assign accept    = in_valid & in_ready;
  assign or_free   = ~or_valid_q | out_ready;
  assign out_valid = or_valid_q;
  assign out_ctrl  = or_ctrl_q;
  assign out_pc    = or_pc_q;

  always_comb begin
    or_valid_d = or_valid_q;
    or_ctrl_d  = or_ctrl_q;
    or_pc_d    = or_pc_q;
    sk_valid_d = sk_valid_q;
    sk_ctrl_d  = sk_ctrl_q;
    sk_pc_d    = sk_pc_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (or_free) begin
      // A full skid implies in_ready=0, so no accept can collide with the refill.
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_ctrl_d  = sk_ctrl_q;
        or_pc_d    = sk_pc_q;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_valid_d = 1'b1;
        or_ctrl_d  = dec_ctrl;
        or_pc_d    = in_pc;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_ctrl_d  = dec_ctrl;
      sk_pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_ctrl_q  <= '0;
      or_pc_q    <= RESET_PC;
      sk_valid_q <= 1'b0;
      sk_ctrl_q  <= '0;
      sk_pc_q    <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_ctrl_q  <= or_ctrl_d;
      or_pc_q    <= or_pc_d;
      sk_valid_q <= sk_valid_d;
      sk_ctrl_q  <= sk_ctrl_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus backpressure and flush sequences.
module tb_decode_stage;
  import decode_pkg::*;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]  in_instr, in_pc, out_pc;
  decode_ctrl_t out_ctrl;

  int n_cmp  = 0;
  int n_fail = 0;

  decode_stage u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [1:0]  src_a;
    logic        src_b, rw, mr, mw, br, jmp, ill;
    logic        chk_imm, chk_dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                              input logic [4:0] op, input logic [1:0] sa, input logic sb,
                              input logic rw, input logic mr, input logic mw, input logic br,
                              input logic jmp, input logic ill, input logic ci,
                              input logic cd);
    vec_t v;
    v.instr = instr; v.imm = imm; v.alu_op = op; v.src_a = sa; v.src_b = sb;
    v.rw = rw; v.mr = mr; v.mw = mw; v.br = br; v.jmp = jmp; v.ill = ill;
    v.chk_imm = ci; v.chk_dp = cd;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;

    // instr, imm, alu_op, src_a, src_b, rw, mr, mw, br, jmp, ill, chk_imm, chk_dp
    vecs.push_back(mk(32'h00500093, 32'h5,        5'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h12345137, 32'h12345000, 5'd0, 2'd2, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h00000013, 32'h0,        5'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h402081B3, 32'h0,        5'd1, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(32'h00208463, 32'h8,        5'd1, 2'd0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(32'hFFC0A283, 32'hFFFFFFFC, 5'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h0020A623, 32'hC,        5'd0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h010000EF, 32'h10,       5'd0, 2'd1, 1, 1, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(32'h00001217, 32'h1000,     5'd0, 2'd1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h4030D093, 32'h403,      5'd9, 2'd0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(32'h000110E7, 32'h0,        5'd0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(32'h40309093, 32'h0,        5'd0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(32'h00500091, 32'h0,        5'd0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(32'h0000007F, 32'h0,        5'd0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
`ifdef DECODE_RV32M_EN
    vecs.push_back(mk(32'h02208033, 32'h0,        5'd10, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`else
    vecs.push_back(mk(32'h02208033, 32'h0,        5'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`endif

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.out_valid", 96'(out_valid), 96'(0));
    check("rst.in_ready",  96'(in_ready),  96'(1));
    check("rst.out_ctrl",  96'(out_ctrl),  96'(0));
    check("rst.out_pc",    96'(out_pc),    96'(0));

    // Decode table, one instruction at a time with out_ready high
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h100 + 32'(4 * i);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d.out_valid", i), 96'(out_valid), 96'(1));
      check($sformatf("v%0d.out_pc", i), 96'(out_pc), 96'(32'h100 + 32'(4 * i)));
      if (vecs[i].chk_imm) check($sformatf("v%0d.imm", i), 96'(out_ctrl.imm), 96'(vecs[i].imm));
      if (vecs[i].chk_dp) begin
        check($sformatf("v%0d.alu_op", i), 96'(out_ctrl.alu_op), 96'(vecs[i].alu_op));
        check($sformatf("v%0d.src_a", i), 96'(out_ctrl.src_a), 96'(vecs[i].src_a));
        check($sformatf("v%0d.src_b", i), 96'(out_ctrl.alu_src_b), 96'(vecs[i].src_b));
      end
      check($sformatf("v%0d.reg_write", i), 96'(out_ctrl.reg_write), 96'(vecs[i].rw));
      check($sformatf("v%0d.mem_read", i), 96'(out_ctrl.mem_read), 96'(vecs[i].mr));
      check($sformatf("v%0d.mem_write", i), 96'(out_ctrl.mem_write), 96'(vecs[i].mw));
      check($sformatf("v%0d.branch", i), 96'(out_ctrl.branch), 96'(vecs[i].br));
      check($sformatf("v%0d.jump", i), 96'(out_ctrl.jump), 96'(vecs[i].jmp));
      check($sformatf("v%0d.illegal", i), 96'(out_ctrl.illegal), 96'(vecs[i].ill));
    end
    @(negedge clk);
    check("idle.out_valid", 96'(out_valid), 96'(0));

    // Backpressure: A into OR, B into skid, C held off; then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h200;
    @(posedge clk); @(negedge clk);
    check("bp.a_valid", 96'(out_valid), 96'(1));
    check("bp.a_ready", 96'(in_ready), 96'(1));
    in_instr = 32'h12345137; in_pc = 32'h204;
    @(posedge clk); @(negedge clk);
    check("bp.sk_full_ready", 96'(in_ready), 96'(0));
    check("bp.a_pc_hold", 96'(out_pc), 96'(32'h200));
    in_instr = 32'h00000013; in_pc = 32'h208;
    @(posedge clk); @(negedge clk);
    check("bp.stall_ready", 96'(in_ready), 96'(0));
    check("bp.stall_pc", 96'(out_pc), 96'(32'h200));
    check("bp.stall_imm", 96'(out_ctrl.imm), 96'(5));
    check("bp.stall_rd", 96'(out_ctrl.rd), 96'(1));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp.b_pc", 96'(out_pc), 96'(32'h204));
    check("bp.b_imm", 96'(out_ctrl.imm), 96'(32'h12345000));
    check("bp.b_ready", 96'(in_ready), 96'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("bp.c_valid", 96'(out_valid), 96'(1));
    check("bp.c_pc", 96'(out_pc), 96'(32'h208));
    check("bp.c_rd", 96'(out_ctrl.rd), 96'(0));
    @(posedge clk); @(negedge clk);
    check("bp.empty", 96'(out_valid), 96'(0));

    // Flush with OR and skid full while a third instr is offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300;
    @(posedge clk); @(negedge clk);
    in_instr = 32'h12345137; in_pc = 32'h304;
    @(posedge clk); @(negedge clk);
    check("fl.pre_ready", 96'(in_ready), 96'(0));
    in_instr = 32'h00000013; in_pc = 32'h308; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl.out_valid", 96'(out_valid), 96'(0));
    check("fl.in_ready", 96'(in_ready), 96'(1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("fl.quiet%0d", k), 96'(out_valid), 96'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
